// File: rtl/matrix_stream_pkg.sv
// Shared types and elaboration helpers for the ping-pong matrix stream transpose.
package matrix_stream_pkg;

    typedef enum logic {
        MODE_TRANSPOSE   = 1'b0,
        MODE_PASSTHROUGH = 1'b1
    } mode_e;

    // Counter width for a range of 'value' entries, never narrower than one bit.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int grid_size(input int total_dim, input int compute_dim);
        return total_dim / compute_dim;
    endfunction

endpackage

// File: rtl/matrix_chunk_bank.sv
// One full-matrix chunk store: registered write, combinational read, plus the
// bank's full flag and the mode latched from the matrix's first chunk.
module matrix_chunk_bank
    import matrix_stream_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int CHUNK_W = 32,
    parameter int ADDR_W  = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  wr_addr,
    input  logic [CHUNK_W-1:0] wr_data,
    input  logic               wr_first,
    input  logic               wr_last,
    input  mode_e              wr_mode,
    input  logic               rd_done,
    input  logic [ADDR_W-1:0]  rd_addr,
    output logic [CHUNK_W-1:0] rd_data,
    output logic               full,
    output mode_e              mode
);

    logic [CHUNK_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

    // A bank is never written while full, so set and clear cannot collide.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full <= 1'b0;
            mode <= MODE_TRANSPOSE;
        end else begin
            if (wr_en && wr_first) begin
                mode <= wr_mode;
            end
            if (wr_en && wr_last) begin
                full <= 1'b1;
            end else if (rd_done) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/matrix_stream_transpose_pp.sv
// Multi-bank streaming chunk transpose with per-matrix transpose/passthrough mode.
// Optional MATRIX_STREAM_TRANSPOSE_LAST_EN adds in_last/out_last framing and err_framing.
module matrix_stream_transpose_pp
    import matrix_stream_pkg::*;
#(
    parameter int TOTAL_DIM0   = 4,
    parameter int TOTAL_DIM1   = 4,
    parameter int COMPUTE_DIM0 = 2,
    parameter int COMPUTE_DIM1 = 2,
    parameter int DATA_WIDTH   = 8,
    parameter int NUM_BANKS    = 2
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [COMPUTE_DIM0*COMPUTE_DIM1*DATA_WIDTH-1:0] in_data,
    input  logic                                          in_mode,
    input  logic                                          in_valid,
    output logic                                          in_ready,
    output logic [COMPUTE_DIM0*COMPUTE_DIM1*DATA_WIDTH-1:0] out_data,
    output logic                                          out_mode,
    output logic                                          out_valid,
    input  logic                                          out_ready
`ifdef MATRIX_STREAM_TRANSPOSE_LAST_EN
    ,
    input  logic                                          in_last,
    output logic                                          out_last,
    output logic                                          err_framing
`endif
);

    localparam int IN_ROWS  = grid_size(TOTAL_DIM1, COMPUTE_DIM1);
    localparam int IN_COLS  = grid_size(TOTAL_DIM0, COMPUTE_DIM0);
    localparam int N        = IN_ROWS * IN_COLS;
    localparam int CHUNK_W  = COMPUTE_DIM0 * COMPUTE_DIM1 * DATA_WIDTH;
    localparam int ADDR_W   = clog2_min1(N);
    localparam int ROW_W    = clog2_min1(IN_ROWS);
    localparam int COL_W    = clog2_min1(IN_COLS);
    localparam int GRID_MAX = (IN_ROWS > IN_COLS) ? IN_ROWS : IN_COLS;
    localparam int RD_W     = clog2_min1(GRID_MAX);
    localparam int BANK_W   = clog2_min1(NUM_BANKS);

    if ((TOTAL_DIM0 % COMPUTE_DIM0) != 0 || (TOTAL_DIM1 % COMPUTE_DIM1) != 0) begin : g_bad_dims
        $fatal(1, "matrix_stream_transpose_pp: compute dims must divide total dims");
    end
    if (NUM_BANKS < 1) begin : g_bad_banks
        $fatal(1, "matrix_stream_transpose_pp: NUM_BANKS must be at least 1");
    end

    logic [NUM_BANKS-1:0] bank_full;
    mode_e                bank_mode    [NUM_BANKS];
    logic [CHUNK_W-1:0]   bank_rd_data [NUM_BANKS];

    // Write side: row-major fill of wr_bank.
    logic [BANK_W-1:0] wr_bank;
    logic [ROW_W-1:0]  wr_row;
    logic [COL_W-1:0]  wr_col;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_accept;
    logic              wr_col_end;
    logic              wr_is_first;
    logic              wr_is_last;

    assign in_ready    = !bank_full[wr_bank];
    assign wr_accept   = in_valid && in_ready;
    assign wr_col_end  = (wr_col == COL_W'(IN_COLS - 1));
    assign wr_is_last  = wr_col_end && (wr_row == ROW_W'(IN_ROWS - 1));
    assign wr_is_first = (wr_row == '0) && (wr_col == '0);
    assign wr_addr     = ADDR_W'(32'(wr_row) * 32'(IN_COLS) + 32'(wr_col));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_bank <= '0;
            wr_row  <= '0;
            wr_col  <= '0;
        end else if (wr_accept) begin
            if (wr_is_last) begin
                wr_row  <= '0;
                wr_col  <= '0;
                wr_bank <= (wr_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : wr_bank + 1'b1;
            end else if (wr_col_end) begin
                wr_col <= '0;
                wr_row <= wr_row + 1'b1;
            end else begin
                wr_col <= wr_col + 1'b1;
            end
        end
    end

    // Read side: rd_row/rd_col walk the output grid, whose shape depends on mode.
    logic [BANK_W-1:0] rd_bank;
    logic [RD_W-1:0]   rd_row;
    logic [RD_W-1:0]   rd_col;
    logic [RD_W-1:0]   rows_last;
    logic [RD_W-1:0]   cols_last;
    logic [RD_W-1:0]   src_row;
    logic [RD_W-1:0]   src_col;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_accept;
    logic              rd_is_last;
    mode_e             cur_mode;
    logic [CHUNK_W-1:0] raw_chunk;

    assign cur_mode   = bank_mode[rd_bank];
    assign raw_chunk  = bank_rd_data[rd_bank];
    assign out_valid  = bank_full[rd_bank];
    assign out_mode   = cur_mode;
    assign rd_accept  = out_valid && out_ready;
    assign rd_is_last = (rd_row == rows_last) && (rd_col == cols_last);
    assign rd_addr    = ADDR_W'(32'(src_row) * 32'(IN_COLS) + 32'(src_col));

    always_comb begin
        rows_last = RD_W'(IN_ROWS - 1);
        cols_last = RD_W'(IN_COLS - 1);
        src_row   = rd_row;
        src_col   = rd_col;
        if (cur_mode == MODE_TRANSPOSE) begin
            rows_last = RD_W'(IN_COLS - 1);
            cols_last = RD_W'(IN_ROWS - 1);
            src_row   = rd_col;
            src_col   = rd_row;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_bank <= '0;
            rd_row  <= '0;
            rd_col  <= '0;
        end else if (rd_accept) begin
            if (rd_is_last) begin
                rd_row  <= '0;
                rd_col  <= '0;
                rd_bank <= (rd_bank == BANK_W'(NUM_BANKS - 1)) ? '0 : rd_bank + 1'b1;
            end else if (rd_col == cols_last) begin
                rd_col <= '0;
                rd_row <= rd_row + 1'b1;
            end else begin
                rd_col <= rd_col + 1'b1;
            end
        end
    end

    // Element-level transpose inside the chunk: out[j*C1+i] = in[i*C0+j].
    always_comb begin
        out_data = raw_chunk;
        if (cur_mode == MODE_TRANSPOSE) begin
            for (int i = 0; i < COMPUTE_DIM1; i++) begin
                for (int j = 0; j < COMPUTE_DIM0; j++) begin
                    out_data[(j*COMPUTE_DIM1 + i)*DATA_WIDTH +: DATA_WIDTH] =
                        raw_chunk[(i*COMPUTE_DIM0 + j)*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        matrix_chunk_bank #(
            .DEPTH   (N),
            .CHUNK_W (CHUNK_W),
            .ADDR_W  (ADDR_W)
        ) u_bank (
            .clk      (clk),
            .rst      (rst),
            .wr_en    (wr_accept && (wr_bank == BANK_W'(b))),
            .wr_addr  (wr_addr),
            .wr_data  (in_data),
            .wr_first (wr_is_first),
            .wr_last  (wr_is_last),
            .wr_mode  (mode_e'(in_mode)),
            .rd_done  (rd_accept && rd_is_last && (rd_bank == BANK_W'(b))),
            .rd_addr  (rd_addr),
            .rd_data  (bank_rd_data[b]),
            .full     (bank_full[b]),
            .mode     (bank_mode[b])
        );
    end

`ifdef MATRIX_STREAM_TRANSPOSE_LAST_EN
    assign out_last = out_valid && rd_is_last;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_framing <= 1'b0;
        end else if (wr_accept && (in_last != wr_is_last)) begin
            err_framing <= 1'b1;
        end
    end
`endif

endmodule
